// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, op-select
// codes and the default iteration count.
package muldiv_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_EXC   = 3'd4;

    localparam logic MD_SEL_MULT = 1'b0;
    localparam logic MD_SEL_DIV  = 1'b1;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_RUN   = S_RUN,
        ST_WRITE = S_WRITE,
        ST_EXC   = S_EXC
    } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/handshake bundle between the main control FSM, the sequencer and the
// iterative multiply/divide unit. master = control side, slave = sequencer.
interface muldiv_sequencer_if;

    logic req_mult;
    logic req_div;
    logic divisor_zero;
    logic md_sel;
    logic md_load;
    logic md_step;
    logic hilo_write;
    logic busy;
    logic done;
    logic div0_exc;

    modport master (
        output req_mult, req_div, divisor_zero,
        input  md_sel, md_load, md_step, hilo_write, busy, done, div0_exc
    );

    modport slave (
        input  req_mult, req_div, divisor_zero,
        output md_sel, md_load, md_step, hilo_write, busy, done, div0_exc
    );

endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV: LOAD, ITER step cycles, then a HI/LO write with done.
// Optional divide-by-zero trap enabled by defining MULDIV_DIV0_TRAP_EN.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int ITER  = ITER_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             md_sel, md_sel_nxt;
    logic             md_load, md_step, hilo_write, done, div0_exc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            md_sel <= MD_SEL_MULT;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            md_sel <= md_sel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        md_sel_nxt = md_sel;
        md_load    = 1'b0;
        md_step    = 1'b0;
        hilo_write = 1'b0;
        done       = 1'b0;
        div0_exc   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Mult takes priority; a simultaneous div request is dropped.
                if (bus.req_mult) begin
                    md_sel_nxt = MD_SEL_MULT;
                    state_nxt  = ST_LOAD;
                end else if (bus.req_div) begin
                    md_sel_nxt = MD_SEL_DIV;
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                md_load = 1'b1;
                cnt_nxt = '0;
`ifdef MULDIV_DIV0_TRAP_EN
                if (md_sel == MD_SEL_DIV && bus.divisor_zero)
                    state_nxt = ST_EXC;
                else
                    state_nxt = ST_RUN;
`else
                state_nxt = ST_RUN;
`endif
            end
            ST_RUN: begin
                md_step = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST)
                    state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                hilo_write = 1'b1;
                done       = 1'b1;
                state_nxt  = ST_IDLE;
            end
`ifdef MULDIV_DIV0_TRAP_EN
            ST_EXC: begin
                div0_exc  = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifndef MULDIV_DIV0_TRAP_EN
    logic unused_divisor_zero;
    assign unused_divisor_zero = bus.divisor_zero;
`endif

    assign bus.md_sel     = md_sel;
    assign bus.md_load    = md_load;
    assign bus.md_step    = md_step;
    assign bus.hilo_write = hilo_write;
    assign bus.done       = done;
    assign bus.div0_exc   = div0_exc;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: cycle-indexed observation of each operation.
module tb_muldiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer_if ifc ();

    muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    // Observation results, indexed by cycle k after the request-sampling edge.
    int n_load, n_step, n_write, n_done, n_exc;
    int first_load_k, first_step_k, last_step_k, first_done_k, last_done_k, first_write_k;
    int last_busy_k, n_sel0, n_sel1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic observe(input int cycles, input int hold);
        n_load = 0; n_step = 0; n_write = 0; n_done = 0; n_exc = 0;
        first_load_k = -1; first_step_k = -1; last_step_k = -1;
        first_done_k = -1; last_done_k = -1; first_write_k = -1;
        last_busy_k = -1; n_sel0 = 0; n_sel1 = 0;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            if (k == hold) begin
                ifc.req_mult = 1'b0;
                ifc.req_div  = 1'b0;
            end
            if (ifc.md_load) begin
                n_load++;
                if (first_load_k < 0) first_load_k = k;
            end
            if (ifc.md_step) begin
                n_step++;
                if (first_step_k < 0) first_step_k = k;
                last_step_k = k;
            end
            if (ifc.hilo_write) begin
                n_write++;
                if (first_write_k < 0) first_write_k = k;
            end
            if (ifc.done) begin
                n_done++;
                if (first_done_k < 0) first_done_k = k;
                last_done_k = k;
            end
            if (ifc.div0_exc) n_exc++;
            if (ifc.busy) begin
                last_busy_k = k;
                if (ifc.md_sel) n_sel1++; else n_sel0++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({ifc.busy, ifc.done, ifc.md_sel, ifc.md_load, ifc.md_step, ifc.hilo_write, ifc.div0_exc} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {ifc.busy, ifc.done, ifc.md_sel, ifc.md_load, ifc.md_step, ifc.hilo_write, ifc.div0_exc});
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({ifc.busy, ifc.md_load} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy/load got %b expected 00", {ifc.busy, ifc.md_load});
        end
    endtask

    task automatic test_mult();
        ifc.req_mult = 1'b1;
        observe(36, 1);
        checks++;
        if (first_load_k !== 1 || n_load !== 1) begin
            errors++;
            $display("FAIL mult_load: at %0d count %0d expected at 1 count 1", first_load_k, n_load);
        end
        checks++;
        if (n_step !== 32 || first_step_k !== 2 || last_step_k !== 33) begin
            errors++;
            $display("FAIL mult_steps: %0d steps %0d..%0d expected 32 steps 2..33", n_step, first_step_k, last_step_k);
        end
        checks++;
        if (first_write_k !== 34 || first_done_k !== 34 || n_write !== 1 || n_done !== 1) begin
            errors++;
            $display("FAIL mult_done: write@%0d done@%0d (%0d,%0d) expected 34,34 (1,1)",
                     first_write_k, first_done_k, n_write, n_done);
        end
        checks++;
        if (last_busy_k !== 34 || n_sel1 !== 0) begin
            errors++;
            $display("FAIL mult_busy_sel: last busy %0d sel1 cycles %0d expected 34 and 0", last_busy_k, n_sel1);
        end
    endtask

    task automatic test_div();
        ifc.divisor_zero = 1'b0;
        ifc.req_div = 1'b1;
        observe(36, 1);
        checks++;
        if (n_sel1 !== 34 || n_sel0 !== 0) begin
            errors++;
            $display("FAIL div_sel: sel1 %0d sel0 %0d expected 34 and 0", n_sel1, n_sel0);
        end
        checks++;
        if (n_step !== 32 || first_done_k !== 34 || n_write !== 1 || n_exc !== 0) begin
            errors++;
            $display("FAIL div_seq: steps %0d done@%0d writes %0d exc %0d expected 32,34,1,0",
                     n_step, first_done_k, n_write, n_exc);
        end
    endtask

    task automatic test_both();
        ifc.req_mult = 1'b1;
        ifc.req_div  = 1'b1;
        observe(40, 1);
        checks++;
        if (n_sel1 !== 0 || n_sel0 !== 34) begin
            errors++;
            $display("FAIL both_sel: sel1 %0d sel0 %0d expected 0 and 34", n_sel1, n_sel0);
        end
        checks++;
        if (n_done !== 1 || n_load !== 1) begin
            errors++;
            $display("FAIL both_single: done %0d load %0d expected 1 and 1", n_done, n_load);
        end
    endtask

    task automatic test_div0();
        ifc.divisor_zero = 1'b1;
        ifc.req_div = 1'b1;
        observe(36, 1);
        ifc.divisor_zero = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
        checks++;
        if (first_done_k !== 2 || n_exc !== 1 || n_done !== 1) begin
            errors++;
            $display("FAIL div0_trap: done@%0d exc %0d done %0d expected 2,1,1", first_done_k, n_exc, n_done);
        end
        checks++;
        if (n_step !== 0 || n_write !== 0 || last_busy_k !== 2) begin
            errors++;
            $display("FAIL div0_no_run: steps %0d writes %0d last busy %0d expected 0,0,2",
                     n_step, n_write, last_busy_k);
        end
`else
        checks++;
        if (n_step !== 32 || first_write_k !== 34 || n_write !== 1) begin
            errors++;
            $display("FAIL div0_full: steps %0d write@%0d writes %0d expected 32,34,1",
                     n_step, first_write_k, n_write);
        end
        checks++;
        if (n_exc !== 0) begin
            errors++;
            $display("FAIL div0_exc_tied: exc %0d expected 0", n_exc);
        end
`endif
    endtask

    task automatic test_reset_mid();
        ifc.req_mult = 1'b1;
        observe(11, 1);
        checks++;
        if (n_step !== 10 || ifc.md_step !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: steps %0d step now %b expected 10 and 1", n_step, ifc.md_step);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ifc.busy, ifc.done, ifc.md_sel, ifc.md_load, ifc.md_step, ifc.hilo_write, ifc.div0_exc} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 0000000",
                     {ifc.busy, ifc.done, ifc.md_sel, ifc.md_load, ifc.md_step, ifc.hilo_write, ifc.div0_exc});
        end
        observe(3, 0);
        checks++;
        if (n_write !== 0 || n_step !== 0) begin
            errors++;
            $display("FAIL mid_reset_hold: writes %0d steps %0d expected 0 and 0", n_write, n_step);
        end
        reset = 1'b0;
        ifc.req_mult = 1'b1;
        observe(36, 1);
        checks++;
        if (first_done_k !== 34 || n_write !== 1 || n_step !== 32) begin
            errors++;
            $display("FAIL mid_recover: done@%0d writes %0d steps %0d expected 34,1,32",
                     first_done_k, n_write, n_step);
        end
    endtask

    task automatic test_back_to_back();
        ifc.req_mult = 1'b1;
        observe(75, 36);
        checks++;
        if (n_done !== 2 || first_done_k !== 34 || last_done_k !== 69) begin
            errors++;
            $display("FAIL b2b_done: count %0d at %0d and %0d expected 2 at 34 and 69",
                     n_done, first_done_k, last_done_k);
        end
        checks++;
        if (n_step !== 64 || n_load !== 2 || n_write !== 2) begin
            errors++;
            $display("FAIL b2b_counts: steps %0d loads %0d writes %0d expected 64,2,2",
                     n_step, n_load, n_write);
        end
    endtask

    initial begin
        ifc.req_mult     = 1'b0;
        ifc.req_div      = 1'b0;
        ifc.divisor_zero = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_both();
        test_div0();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
